// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx transmitter between N_REQ byte sources.
// Optional build macro UART_ARB_FRAME_LOCK_EN keeps the grant on one requester until it marks its last byte.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_din,
    output logic                 tx_wr_en,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 arb_busy,
    output logic [15:0]          byte_cnt
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    // Resetting to the highest index makes the first search begin at requester 0.
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic [1:0]       state;
    logic [N_REQ-1:0] eligible;
    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic [7:0]       pick_byte;
    logic [N_REQ-1:0] pick_onehot;

`ifdef UART_ARB_FRAME_LOCK_EN
    logic lock;
    logic owner_last;

    // While locked, only the current owner may be granted again.
    always_comb begin
        eligible   = req_valid;
        owner_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                owner_last = req_last[i];
            end else if (lock) begin
                eligible[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            lock <= 1'b0;
        end else if (state == S_ISSUE) begin
            lock <= !owner_last;
        end
    end
`else
    logic unused_last;

    assign eligible    = req_valid;
    assign unused_last = ^req_last;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    // Two passes give the rotating priority: indices above the last grant first, then wrap around.
    always_comb begin
        pick_found  = 1'b0;
        pick_id     = grant_id;
        pick_byte   = 8'h00;
        pick_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && (i > int'(grant_id)) && eligible[i]) begin
                pick_found     = 1'b1;
                pick_id        = ID_W'(i);
                pick_byte      = req_data[8*i +: 8];
                pick_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && (i <= int'(grant_id)) && eligible[i]) begin
                pick_found     = 1'b1;
                pick_id        = ID_W'(i);
                pick_byte      = req_data[8*i +: 8];
                pick_onehot[i] = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= '0;
            tx_wr_en  <= 1'b0;
            tx_din    <= 8'h00;
            grant_id  <= LAST_ID;
            byte_cnt  <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!tx_busy && pick_found) begin
                        tx_din    <= pick_byte;
                        grant_id  <= pick_id;
                        tx_wr_en  <= 1'b1;
                        req_ready <= pick_onehot;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_wr_en  <= 1'b0;
                    req_ready <= '0;
                    byte_cnt  <= byte_cnt + 16'd1;
                    state     <= S_WAIT_BUSY;
                end
                // uart_tx raises busy one edge after the strobe; issuing before then would double-write.
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign arb_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a uart_tx busy model drive the DUT,
// a monitor pops expected issues whenever tx_wr_en is seen.
module tb_uart_tx_arbiter;

    localparam int N_REQ     = 4;
    localparam int ID_W      = 2;
    localparam int FRAME_CYC = 10;

    logic                 pclk = 1'b0;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     req_ready;
    logic [7:0]           tx_din;
    logic                 tx_wr_en;
    logic                 tx_busy;
    logic [ID_W-1:0]      grant_id;
    logic                 arb_busy;
    logic [15:0]          byte_cnt;

    logic                 foreign_busy;
    int                   uart_cnt = 0;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      data;
        logic [15:0]     cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [8:0]  src_q[N_REQ][$];
    logic [15:0] exp_cnt;
    int          errors = 0;
    int          checks = 0;
    int          issue_cnt = 0;

    uart_tx_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_din    (tx_din),
        .tx_wr_en  (tx_wr_en),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy),
        .byte_cnt  (byte_cnt)
    );

    always #5 pclk = ~pclk;

    // uart_tx stand-in: busy from the edge after wr_en for FRAME_CYC cycles; not affected by rst_n.
    always @(posedge pclk) begin
        if (tx_wr_en) uart_cnt <= FRAME_CYC;
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end
    assign tx_busy = (uart_cnt != 0) || foreign_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic expect_issue(input int r, input logic [7:0] d);
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back('{id: ID_W'(r), data: d, cnt: exp_cnt});
    endtask

    task automatic wait_wr_en(input int budget, output int cyc);
        cyc = 0;
        while (tx_wr_en !== 1'b1 && cyc < budget) begin
            @(negedge pclk);
            cyc++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        int pending;
        n = 0;
        pending = 1;
        while (pending != 0 && n < budget) begin
            pending = exp_q.size();
            for (int i = 0; i < N_REQ; i++) pending += src_q[i].size();
            if (arb_busy || tx_busy) pending++;
            if (pending != 0) begin
                @(negedge pclk);
                n++;
            end
        end
        checks++;
        if (pending != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expected issues still pending after %0d cycles", exp_q.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        foreign_busy = 1'b0;
        repeat (2) @(negedge pclk);
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        exp_q.delete();
        exp_cnt = 16'h0000;
        rst_n = 1'b1;
    endtask

    // Requester model: a byte leaves its queue after a valid&ready edge.
    initial begin
        logic [N_REQ-1:0] xfer;
        logic [8:0]       head;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge pclk);
            xfer = req_valid & req_ready;
            @(posedge pclk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    head = src_q[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = head[7:0];
                    req_last[i]        = head[8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every strobe must match the next expected issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (rst_n === 1'b1 && tx_wr_en === 1'b1) begin
                issue_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_en: got tx_din=%0h grant_id=%0d, expected no issue", tx_din, grant_id);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_din", tx_din, e.data);
                    check("grant_id", grant_id, e.id);
                    check("req_ready", req_ready, N_REQ'(1) << e.id);
                    check("busy_at_issue", tx_busy, 1'b0);
                    @(negedge pclk);
                    check("byte_cnt", byte_cnt, e.cnt);
                    check("wr_en_pulse", tx_wr_en, 1'b0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        foreign_busy = 1'b0;
        exp_cnt = 16'h0000;
        repeat (2) @(negedge pclk);
        check("rst_arb_busy", arb_busy, 1'b0);
        check("rst_wr_en", tx_wr_en, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_tx_din", tx_din, 8'h00);
        check("rst_grant_id", grant_id, 2'd3);
        check("rst_byte_cnt", byte_cnt, 16'h0000);
        rst_n = 1'b1;

        // 1: single byte, latency, then a second byte only after busy falls
        push_src(0, 8'hA5, 1'b1);
        expect_issue(0, 8'hA5);
        wait_wr_en(20, cyc);
        check("t1_latency", cyc, 2);
        push_src(0, 8'hA6, 1'b1);
        expect_issue(0, 8'hA6);
        drain(200);
        check("t1_grant_id", grant_id, 2'd0);
        check("t1_byte_cnt", byte_cnt, 16'd2);

        // 2: all valid -> 0,1,2,3,0
        do_reset();
        push_src(0, 8'h10, 1'b1);
        push_src(0, 8'h10, 1'b1);
        push_src(1, 8'h11, 1'b1);
        push_src(2, 8'h12, 1'b1);
        push_src(3, 8'h13, 1'b1);
        expect_issue(0, 8'h10);
        expect_issue(1, 8'h11);
        expect_issue(2, 8'h12);
        expect_issue(3, 8'h13);
        expect_issue(0, 8'h10);
        drain(400);
        check("t2_byte_cnt", byte_cnt, 16'd5);

        // 3: foreign busy in IDLE blocks issue
        do_reset();
        foreign_busy = 1'b1;
        cyc = issue_cnt;
        push_src(1, 8'h5C, 1'b1);
        expect_issue(1, 8'h5C);
        repeat (8) @(negedge pclk);
        check("t3_blocked", issue_cnt - cyc, 0);
        check("t3_arb_idle", arb_busy, 1'b0);
        foreign_busy = 1'b0;
        wait_wr_en(20, cyc);
        check("t3_latency", cyc, 1);
        check("t3_grant_id", grant_id, 2'd1);
        drain(200);

        // 4: async reset during WAIT_DONE
        do_reset();
        push_src(0, 8'h77, 1'b1);
        expect_issue(0, 8'h77);
        wait_wr_en(20, cyc);
        repeat (3) @(negedge pclk);
        check("t4_in_wait_done", {arb_busy, tx_busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("t4_rst_wr_en", tx_wr_en, 1'b0);
        check("t4_rst_req_ready", req_ready, 4'b0000);
        check("t4_rst_tx_din", tx_din, 8'h00);
        check("t4_rst_grant_id", grant_id, 2'd3);
        check("t4_rst_byte_cnt", byte_cnt, 16'h0000);
        check("t4_rst_arb_busy", arb_busy, 1'b0);
        exp_cnt = 16'h0000;
        push_src(3, 8'h3C, 1'b1);
        expect_issue(3, 8'h3C);
        @(negedge pclk);
        rst_n = 1'b1;
        drain(200);

        // 5: byte counter wrap
        do_reset();
        @(negedge pclk);
        force dut.byte_cnt = 16'hFFFF;
        @(negedge pclk);
        release dut.byte_cnt;
        @(negedge pclk);
        check("t5_preload", byte_cnt, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        push_src(2, 8'h5A, 1'b1);
        expect_issue(2, 8'h5A);
        drain(200);
        check("t5_wrap", byte_cnt, 16'h0000);

        // 6: multi-byte frame from r0 with r1 competing
        do_reset();
        push_src(0, 8'hA0, 1'b0);
        push_src(0, 8'hA1, 1'b0);
        push_src(0, 8'hA2, 1'b1);
        push_src(1, 8'hB0, 1'b1);
        push_src(1, 8'hB1, 1'b1);
`ifdef UART_ARB_FRAME_LOCK_EN
        expect_issue(0, 8'hA0);
        expect_issue(0, 8'hA1);
        expect_issue(0, 8'hA2);
        expect_issue(1, 8'hB0);
        expect_issue(1, 8'hB1);
`else
        expect_issue(0, 8'hA0);
        expect_issue(1, 8'hB0);
        expect_issue(0, 8'hA1);
        expect_issue(1, 8'hB1);
        expect_issue(0, 8'hA2);
`endif
        drain(400);
        check("t6_byte_cnt", byte_cnt, 16'd5);

        repeat (3) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
